// File: rtl/repeat_btn_conditioner_pkg.sv
// Shared definitions for the ring-flasher button path.
//   btn_state_e             debounce FSM state encodings
//   CLK_FREQ_HZ             system clock frequency, shared with ring_flasher
//   debounce_cycles_for_ms  converts a debounce window in ms to clock cycles
`timescale 1ns/1ps
package repeat_btn_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_PEND   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_PEND = 2'd3
   } btn_state_e;

   localparam int unsigned CLK_FREQ_HZ = 50_000_000;

   function automatic int unsigned debounce_cycles_for_ms(input int unsigned ms);
      return (CLK_FREQ_HZ / 1000) * ms;
   endfunction

endpackage

// File: rtl/repeat_btn_conditioner_if.sv
// Button-conditioner signal bundle.
//   btn_in         raw asynchronous button level (active-high)
//   repeat_signal  debounced level feeding ring_flasher.repeat_signal
//   press_pulse    1-cycle strobe on accepted press
//   release_pulse  1-cycle strobe on accepted release
// master: the conditioner (consumes btn_in, drives the conditioned outputs)
// slave : the button source / downstream consumer
`timescale 1ns/1ps
interface repeat_btn_conditioner_if;

   logic btn_in;
   logic repeat_signal;
   logic press_pulse;
   logic release_pulse;

   modport master (
      input  btn_in,
      output repeat_signal,
      output press_pulse,
      output release_pulse
   );

   modport slave (
      output btn_in,
      input  repeat_signal,
      input  press_pulse,
      input  release_pulse
   );

endinterface

// File: rtl/repeat_btn_conditioner_sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous bit into the clk
// domain. Reusable for any async input.
//   clk  system clock
//   rst  synchronous reset, active-high, clears every stage to 0
//   d    asynchronous input
//   q    synchronised output (last stage)
`timescale 1ns/1ps
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // NOTE: sequential state is always updated with non-blocking assignments so
   // every flop samples the pre-edge value of its neighbour.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/repeat_btn_conditioner.sv
// repeat_btn_conditioner: synchronises and debounces the ring-flasher retrigger
// button and produces a clean level plus press/release strobes.
//   clk   system clock (50 MHz), rising edge
//   rst   synchronous reset, active-high
//   btn   repeat_btn_conditioner_if.master
//           btn_in -> synchroniser -> debounce FSM -> repeat_signal,
//           press_pulse, release_pulse (all registered)
// A change is accepted only after DEBOUNCE_CYCLES+1 consecutive samples of the
// new level; any reversal before that returns to the previous stable state.
`timescale 1ns/1ps
module repeat_btn_conditioner
   import repeat_btn_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = int'(debounce_cycles_for_ms(20))
) (
   input  logic                      clk,
   input  logic                      rst,
   repeat_btn_conditioner_if.master  btn
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_sync;
   btn_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             repeat_q;
   logic             press_q;
   logic             release_q;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn.btn_in),
      .q   (btn_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RELEASED;
         cnt       <= '0;
         repeat_q  <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         // Strobes default low so each one lasts exactly the transition cycle.
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state)
            ST_RELEASED: begin
               if (btn_sync) begin
                  state <= ST_PRESS_PEND;
                  cnt   <= '0;
               end
            end
            ST_PRESS_PEND: begin
               if (!btn_sync) begin
                  state <= ST_RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state    <= ST_PRESSED;
                  cnt      <= '0;
                  repeat_q <= 1'b1;
                  press_q  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!btn_sync) begin
                  state <= ST_RELEASE_PEND;
                  cnt   <= '0;
               end
            end
            ST_RELEASE_PEND: begin
               if (btn_sync) begin
                  state <= ST_PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ST_RELEASED;
                  cnt       <= '0;
                  repeat_q  <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign btn.repeat_signal = repeat_q;
   assign btn.press_pulse   = press_q;
   assign btn.release_pulse = release_q;

endmodule

// File: tb/tb_repeat_btn_conditioner.sv
// Directed bench for repeat_btn_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4: accepted changes appear on the 7th edge after btn_in
// is first sampled at its new level.
`timescale 1ns/1ps
module tb_repeat_btn_conditioner;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   repeat_btn_conditioner_if bif ();

   repeat_btn_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .btn (bif)
   );

   int n_vectors     = 0;
   int n_miscompares = 0;

   // Downstream observers: strobe counts and rising edges as ring_flasher sees them.
   int   press_cnt   = 0;
   int   release_cnt = 0;
   int   ring_edges  = 0;
   logic repeat_prev = 1'b0;

   always @(negedge clk) begin
      if (bif.press_pulse === 1'b1)   press_cnt   <= press_cnt + 1;
      if (bif.release_pulse === 1'b1) release_cnt <= release_cnt + 1;
      if (bif.repeat_signal === 1'b1 && repeat_prev === 1'b0) ring_edges <= ring_edges + 1;
      repeat_prev <= bif.repeat_signal;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic rs, input logic pp, input logic rp);
      check({tag, ".repeat_signal"}, 32'(bif.repeat_signal), 32'(rs));
      check({tag, ".press_pulse"},   32'(bif.press_pulse),   32'(pp));
      check({tag, ".release_pulse"}, 32'(bif.release_pulse), 32'(rp));
   endtask

   // Hold btn_in at v for n cycles, expecting outputs idle-low throughout.
   task automatic quiet_seg(input string tag, input logic v, input int n);
      bif.btn_in = v;
      for (int i = 0; i < n; i++) begin
         cyc(1);
         check_out(tag, 1'b0, 1'b0, 1'b0);
      end
   endtask

   int p0, r0, e0;

   initial begin
      rst        = 1'b1;
      bif.btn_in = 1'b0;
      cyc(3);
      check_out("reset", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(2);
      check_out("idle", 1'b0, 1'b0, 1'b0);

      // Clean press
      p0 = press_cnt; r0 = release_cnt;
      bif.btn_in = 1'b1;
      cyc(6);
      check_out("press_e6", 1'b0, 1'b0, 1'b0);
      cyc(1);
      check_out("press_e7", 1'b1, 1'b1, 1'b0);
      cyc(1);
      check_out("press_e8", 1'b1, 1'b0, 1'b0);
      cyc(12);
      check("press_count", press_cnt - p0, 1);
      check("press_no_release", release_cnt - r0, 0);

      // 2-cycle low glitch while pressed
      bif.btn_in = 1'b0;
      cyc(2);
      bif.btn_in = 1'b1;
      cyc(10);
      check_out("glitch_held", 1'b1, 1'b0, 1'b0);
      check("glitch_no_release", release_cnt - r0, 0);

      // Release
      bif.btn_in = 1'b0;
      cyc(6);
      check_out("release_e6", 1'b1, 1'b0, 1'b0);
      cyc(1);
      check_out("release_e7", 1'b0, 1'b0, 1'b1);
      cyc(1);
      check_out("release_e8", 1'b0, 1'b0, 1'b0);
      cyc(5);

      // Bounce reject: high 3, low 2, high 3, low
      p0 = press_cnt; r0 = release_cnt;
      quiet_seg("bounce_h1", 1'b1, 3);
      quiet_seg("bounce_l1", 1'b0, 2);
      quiet_seg("bounce_h2", 1'b1, 3);
      quiet_seg("bounce_l2", 1'b0, 8);
      check("bounce_press", press_cnt - p0, 0);
      check("bounce_release", release_cnt - r0, 0);

      // Bounce then settle
      p0 = press_cnt;
      for (int i = 0; i < 3; i++) begin
         quiet_seg("toggle_h", 1'b1, 1);
         quiet_seg("toggle_l", 1'b0, 1);
      end
      bif.btn_in = 1'b1;
      cyc(6);
      check_out("settle_e6", 1'b0, 1'b0, 1'b0);
      cyc(1);
      check_out("settle_e7", 1'b1, 1'b1, 1'b0);
      cyc(10);
      check("settle_press_count", press_cnt - p0, 1);
      bif.btn_in = 1'b0;
      cyc(7);
      check_out("settle_release", 1'b0, 1'b0, 1'b1);
      cyc(3);

      // Reset at count=2 in PRESS_PEND, then again while PRESSED
      p0 = press_cnt; r0 = release_cnt;
      bif.btn_in = 1'b1;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      check_out("rst_pend", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(6);
      check_out("rst_pend_e6", 1'b0, 1'b0, 1'b0);
      cyc(1);
      check_out("rst_pend_e7", 1'b1, 1'b1, 1'b0);
      cyc(3);
      rst = 1'b1;
      cyc(1);
      check_out("rst_pressed", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(6);
      check_out("rst_pressed_e6", 1'b0, 1'b0, 1'b0);
      cyc(1);
      check_out("rst_pressed_e7", 1'b1, 1'b1, 1'b0);
      cyc(3);
      check("rst_press_count", press_cnt - p0, 2);
      check("rst_no_release", release_cnt - r0, 0);
      bif.btn_in = 1'b0;
      cyc(7);
      check_out("rst_release", 1'b0, 1'b0, 1'b1);
      cyc(3);

      // System: two presses 1000 ns apart feeding ring_flasher
      p0 = press_cnt; r0 = release_cnt; e0 = ring_edges;
      bif.btn_in = 1'b1;
      cyc(20);
      bif.btn_in = 1'b0;
      cyc(80);
      check("sys_first_press", press_cnt - p0, 1);
      check("sys_first_edge", ring_edges - e0, 1);
      bif.btn_in = 1'b1;
      cyc(20);
      bif.btn_in = 1'b0;
      cyc(20);
      check("sys_ring_edges", ring_edges - e0, 2);
      check("sys_press_count", press_cnt - p0, 2);
      check("sys_release_count", release_cnt - r0, 2);
      check_out("sys_final", 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
